// File: rtl/iir_pkg.sv
// Shared defaults, derived widths and sample type for the IIR decimator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iir_pkg;

  // W is the sample width minus one, as in the upstream filter.
  localparam int W_DEF = 14;
  // log2 of the decimation factor
  localparam int L_DEF = 2;
  // extra shift that removes the filter's DC gain of 4
  localparam int G_DEF = 2;

  localparam int R_DEF     = 1 << L_DEF;
  localparam int S_DEF     = L_DEF + G_DEF;
  localparam int ACC_W_DEF = W_DEF + 1 + L_DEF;

  typedef logic signed [W_DEF:0] sample_t;

endpackage

// File: rtl/iir_fifo2.sv
// Two-entry synchronous FIFO holding decimated results for the consumer.
// Latency: a push into an empty FIFO is visible on dout after one clock.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
//
// Ports: clk, reset (async, active-low), push/din (write side),
//        pop (ignored when empty), dout (head entry, 0 when empty), empty, full.
module iir_fifo2 #(
  parameter int DW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  // e0 is always the head entry, e1 the one behind it.
  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [1:0]    cnt;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot the push needs, so full+pop still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : e0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iir_decim.sv
// Removes the IIR DC gain, averages R=2^L samples and decimates by R (accumulate-and-dump).
// Latency: result of a block appears on y_out one clock after its last sample.
// Backpressure: y_valid/y_ready through a 2-entry buffer; a result arriving while full
//               with no pop is dropped and sets sticky ovf.
//
// Build option: define IIR_DECIM_ROUND_EN for round-half-up scaling; otherwise the
// scaled result is truncated toward minus infinity.
//
// Ports: clk, reset (async, active-low), x_in (one sample per clock, no handshake),
//        y_out/y_valid/y_ready (decimated output), ovf (sticky drop flag).
module iir_decim
  import iir_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int L = L_DEF,
  parameter int G = G_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [W:0] x_in,
  output logic signed [W:0] y_out,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              ovf
);

  localparam int R     = 1 << L;
  localparam int S     = L + G;
  localparam int ACC_W = W + 1 + L;
  // One guard bit for the rounding add, plus G bits so the shifted value
  // always covers the W+1 result bits.
  localparam int EXT_W = ACC_W + 1 + G;

  logic [L-1:0]             cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [EXT_W-1:0]  sum;
  logic signed [EXT_W-1:0]  scaled;
  logic signed [W:0]        result;
  logic                     dump;
  logic                     empty;
  logic                     full;
  logic                     pop;
  logic                     drop;
  logic                     unused_scaled_msbs;

  assign dump = (cnt == L'(R - 1));
  // Full block sum: the accumulator holds R-1 samples, x_in is the last one.
  assign sum  = EXT_W'(acc) + EXT_W'(x_in);

`ifdef IIR_DECIM_ROUND_EN
  localparam int RND = 1 << (S - 1);
  assign scaled = (sum + EXT_W'(RND)) >>> S;
`else
  assign scaled = sum >>> S;
`endif

  // The scaled value always fits in W+1 bits, so the top bits are only sign copies.
  assign result             = scaled[W:0];
  assign unused_scaled_msbs = ^scaled[EXT_W-1:W+1];

  assign y_valid = !empty;
  assign pop     = y_ready && !empty;
  assign drop    = dump && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      // R is a power of two, so the counter wraps R-1 -> 0 on its own.
      cnt <= cnt + 1'b1;
      if (cnt == '0) acc <= ACC_W'(x_in);
      else           acc <= acc + ACC_W'(x_in);
      if (drop) ovf <= 1'b1;
    end
  end

  iir_fifo2 #(
    .DW (W + 1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dump),
    .din   (result),
    .pop   (pop),
    .dout  (y_out),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_iir_decim.sv
// Directed bench for iir_decim: a queue-based reference model checked every cycle,
// plus hand-computed expectations at chosen points.
module tb_iir_decim;

  localparam int W = 14;
  localparam int L = 2;
  localparam int G = 2;
  localparam int R = 1 << L;
  localparam int DEN = R << G;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic signed [W:0] x_in = '0;
  logic              y_ready = 1'b1;
  logic signed [W:0] y_out;
  logic              y_valid;
  logic              ovf;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // reference model state
  int m_q[$];
  int m_n = 0;
  int m_sum = 0;
  bit m_ovf = 1'b0;
  int m_res;

  always #5 clk = ~clk;

  iir_decim dut (
    .clk     (clk),
    .reset   (reset),
    .x_in    (x_in),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .ovf     (ovf)
  );

  function automatic int fdiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Block average of R samples with the gain of 4 removed.
  function automatic int avg(int s);
`ifdef IIR_DECIM_ROUND_EN
    return fdiv(s + DEN / 2, DEN);
`else
    return fdiv(s, DEN);
`endif
  endfunction

  function void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_n = 0;
      m_sum = 0;
      m_ovf = 1'b0;
    end else begin
      if (m_q.size() > 0 && y_ready) void'(m_q.pop_front());
      m_sum += int'(x_in);
      m_n++;
      if (m_n == R) begin
        m_res = avg(m_sum);
        if (m_q.size() < 2) m_q.push_back(m_res);
        else                m_ovf = 1'b1;
        m_n = 0;
        m_sum = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_y_valid", int'(y_valid), (m_q.size() > 0) ? 1 : 0);
      chk("model_y_out", int'(y_out), (m_q.size() > 0) ? m_q[0] : 0);
      chk("model_ovf", int'(ovf), int'(m_ovf));
    end
  end

  task automatic cyc(input int x, input bit rdy);
    x_in = (W + 1)'(x);
    y_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_y_out", int'(y_out), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 400/16 = 25 in either scaling mode
    repeat (3) begin
      repeat (R) cyc(100, 1'b1);
      chk("dc100_y_out", int'(y_out), 25);
      chk("dc100_y_valid", int'(y_valid), 1);
    end

`ifdef IIR_DECIM_ROUND_EN
    repeat (R) cyc(6, 1'b1);      chk("pos6", int'(y_out), 2);
    repeat (R) cyc(-6, 1'b1);     chk("neg6", int'(y_out), -1);
    repeat (R) cyc(16383, 1'b1);  chk("max", int'(y_out), 4096);
`else
    repeat (R) cyc(6, 1'b1);      chk("pos6", int'(y_out), 1);
    repeat (R) cyc(-6, 1'b1);     chk("neg6", int'(y_out), -2);
    repeat (R) cyc(16383, 1'b1);  chk("max", int'(y_out), 4095);
`endif
    repeat (R) cyc(-16384, 1'b1); chk("min", int'(y_out), -4096);

    // Backpressure: three results with the consumer stalled.
    // First sample still pops the previous result so the buffer starts empty.
    cyc(40, 1'b1);
    repeat (R - 1) cyc(40, 1'b0);
    chk("bp_first", int'(y_out), 10);
    repeat (R) cyc(80, 1'b0);
    chk("bp_full_head", int'(y_out), 10);
    chk("bp_full_ovf", int'(ovf), 0);
    repeat (R) cyc(120, 1'b0);
    chk("bp_drop_head", int'(y_out), 10);
    chk("bp_drop_ovf", int'(ovf), 1);
    cyc(0, 1'b1);
    chk("bp_drain1", int'(y_out), 20);
    cyc(0, 1'b1);
    chk("bp_drain2_valid", int'(y_valid), 0);
    chk("bp_ovf_sticky", int'(ovf), 1);
    // remaining half of this block: 0+0+50+50 = 100 -> 6
    cyc(50, 1'b1);
    cyc(50, 1'b1);
    chk("mixed_block", int'(y_out), 6);

    // Asynchronous reset with two samples of a block already accumulated.
    cyc(50, 1'b0);
    cyc(50, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_y_valid", int'(y_valid), 0);
    chk("arst_y_out", int'(y_out), 0);
    chk("arst_ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (R) cyc(8, 1'b1);
    chk("post_reset_block", int'(y_out), 2);

    // Full buffer with a pop on the dump cycle: nothing may be lost.
    cyc(40, 1'b1);
    repeat (R - 1) cyc(40, 1'b0);
    repeat (R) cyc(80, 1'b0);
    chk("fp_full_head", int'(y_out), 10);
    repeat (R - 1) cyc(120, 1'b0);
    cyc(120, 1'b1);
    chk("fp_head", int'(y_out), 20);
    chk("fp_ovf", int'(ovf), 0);
    cyc(0, 1'b1);
    chk("fp_order", int'(y_out), 30);
    cyc(0, 1'b1);
    chk("fp_empty", int'(y_valid), 0);
    repeat (R) cyc(0, 1'b1);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
